// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one SRAM AXI-lite read port between IFU and LSU, one transaction in flight
module mem_read_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    input  logic [ADDR_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rvalid,
    output logic                  s_rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state_q, state_d;
    logic   gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic   in_addr, in_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: if (ifu_arvalid || lsu_arvalid) begin
                state_d = ADDR;
                gnt_d   = (ifu_arvalid && lsu_arvalid) ? ((ROUND_ROBIN != 0) ? ~last_gnt_q : 1'b1) : lsu_arvalid;
            end
            ADDR: if (s_arvalid && s_arready) state_d = DATA;
            DATA: if (s_rvalid && s_rready) begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // gnt_q: 0 = IFU, 1 = LSU; every output is gated by state so IDLE drives all zeros
    always_comb begin
        in_addr     = (state_q == ADDR);
        in_data     = (state_q == DATA);
        s_araddr    = in_addr ? (gnt_q ? lsu_araddr : ifu_araddr) : '0;
        s_arvalid   = in_addr & (gnt_q ? lsu_arvalid : ifu_arvalid);
        ifu_arready = in_addr & ~gnt_q & s_arready;
        lsu_arready = in_addr & gnt_q & s_arready;
        ifu_rdata   = in_data ? s_rdata : '0;
        lsu_rdata   = in_data ? s_rdata : '0;
        ifu_rvalid  = in_data & ~gnt_q & s_rvalid;
        lsu_rvalid  = in_data & gnt_q & s_rvalid;
        s_rready    = in_data & (gnt_q ? lsu_rready : ifu_rready);
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_mem_read_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ifu_araddr, lsu_araddr, s_rdata;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, s_arready, s_rvalid;
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, s_arvalid, s_rready;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr;
    logic        f_ifu_arready, f_ifu_rvalid, f_lsu_arready, f_lsu_rvalid, f_s_arvalid, f_s_rready;
    logic [31:0] f_ifu_rdata, f_lsu_rdata, f_s_araddr;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_read_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    mem_read_arbiter #(.ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(f_ifu_arready),
        .ifu_rdata(f_ifu_rdata), .ifu_rvalid(f_ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(f_lsu_arready),
        .lsu_rdata(f_lsu_rdata), .lsu_rvalid(f_lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(f_s_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; checks run 1 unit later, well before the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_araddr = '0; lsu_araddr = '0; s_rdata = '0;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        settle();
        chk("reset_s_arvalid", {31'd0, s_arvalid}, 32'd0);
        chk("reset_s_araddr", s_araddr, 32'd0);
        chk("reset_rready", {31'd0, s_rready}, 32'd0);

        // IFU-only read
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; s_arready = 1'b1;
        settle();
        chk("t1_idle_arready", {31'd0, ifu_arready}, 32'd0);
        chk("t1_idle_s_arvalid", {31'd0, s_arvalid}, 32'd0);
        tick(); settle();
        chk("t1_addr_s_araddr", s_araddr, 32'h8000_0000);
        chk("t1_addr_s_arvalid", {31'd0, s_arvalid}, 32'd1);
        chk("t1_addr_ifu_arready", {31'd0, ifu_arready}, 32'd1);
        chk("t1_addr_lsu_arready", {31'd0, lsu_arready}, 32'd0);
        tick();
        ifu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0413;
        settle();
        chk("t1_data_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd1);
        chk("t1_data_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_data_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        chk("t1_data_s_rready", {31'd0, s_rready}, 32'd1);
        tick(); settle();
        // back in IDLE with s_rvalid still high: spurious data must be ignored
        chk("spur_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd0);
        chk("spur_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        chk("spur_s_rready", {31'd0, s_rready}, 32'd0);
        chk("spur_ifu_rdata", ifu_rdata, 32'd0);
        s_rvalid = 1'b0;

        // simultaneous requests from reset, round robin: LSU then IFU
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; s_arready = 1'b1;
        tick(); settle();
        chk("t2_first_s_araddr", s_araddr, 32'h8000_1000);
        chk("t2_first_lsu_arready", {31'd0, lsu_arready}, 32'd1);
        chk("t2_first_ifu_arready", {31'd0, ifu_arready}, 32'd0);
        tick();
        lsu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
        settle();
        chk("t2_first_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd1);
        chk("t2_first_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd0);
        tick();
        s_rvalid = 1'b0;
        settle();
        chk("t2_idle_s_arvalid", {31'd0, s_arvalid}, 32'd0);
        tick(); settle();
        chk("t2_second_s_araddr", s_araddr, 32'h8000_0004);
        chk("t2_second_ifu_arready", {31'd0, ifu_arready}, 32'd1);
        tick();
        ifu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333_4444;
        settle();
        chk("t2_second_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd1);
        chk("t2_second_ifu_rdata", ifu_rdata, 32'h3333_4444);
        tick();
        s_rvalid = 1'b0;

        // continuous requests from both: RR alternates, fixed priority always picks LSU
        do_reset();
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1;
        ifu_araddr = 32'h0000_1000; lsu_araddr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk($sformatf("t3_rr_lsu_arready_%0d", k), {31'd0, lsu_arready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_rr_ifu_arready_%0d", k), {31'd0, ifu_arready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t3_fx_lsu_arready_%0d", k), {31'd0, f_lsu_arready}, 32'd1);
            chk($sformatf("t3_fx_ifu_arready_%0d", k), {31'd0, f_ifu_arready}, 32'd0);
            tick(); settle();
            chk($sformatf("t3_fx_ifu_rvalid_%0d", k), {31'd0, f_ifu_rvalid}, 32'd0);
            tick();
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; s_rvalid = 1'b0;

        // LSU stalls the data phase with rready low
        do_reset();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0040; s_arready = 1'b1;
        tick(); tick();
        lsu_arvalid = 1'b0; lsu_rready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t4_hold_lsu_rvalid_%0d", k), {31'd0, lsu_rvalid}, 32'd1);
            chk($sformatf("t4_hold_lsu_rdata_%0d", k), lsu_rdata, 32'hDEAD_BEEF);
            chk($sformatf("t4_hold_s_rready_%0d", k), {31'd0, s_rready}, 32'd0);
            tick();
        end
        lsu_rready = 1'b1;
        settle();
        chk("t4_release_s_rready", {31'd0, s_rready}, 32'd1);
        tick(); settle();
        chk("t4_idle_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        chk("t4_idle_s_rready", {31'd0, s_rready}, 32'd0);
        s_rvalid = 1'b0;

        // reset while waiting in ADDR
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0100; s_arready = 1'b0;
        tick(); settle();
        chk("t5_addr_s_arvalid", {31'd0, s_arvalid}, 32'd1);
        chk("t5_addr_ifu_arready", {31'd0, ifu_arready}, 32'd0);
        rst_n = 1'b0;
        tick(); settle();
        chk("t5_rst_s_arvalid", {31'd0, s_arvalid}, 32'd0);
        chk("t5_rst_s_araddr", s_araddr, 32'd0);
        chk("t5_rst_ifu_arready", {31'd0, ifu_arready}, 32'd0);
        rst_n = 1'b1; s_arready = 1'b1;
        tick(); settle();
        chk("t5_regrant_s_araddr", s_araddr, 32'h0000_0100);
        chk("t5_regrant_ifu_arready", {31'd0, ifu_arready}, 32'd1);
        tick();
        ifu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
        settle();
        chk("t5_data_ifu_rdata", ifu_rdata, 32'h0BAD_F00D);
        chk("t5_data_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd1);
        tick();
        s_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
